// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser state encoding, frame constants and the
// peripheral register addresses that the memory-mapped block decodes.
// Optional build macro: UART_PARITY_EN (adds an even-parity bit, 8E1 frames).
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_STOP_LEVEL = 1'b1;

    // Register map shared with the peripheral block.
    localparam logic [31:0] UART_TX_DATA_ADDR = 32'h4000_0018;
    localparam logic [31:0] UART_STATUS_ADDR  = 32'h4000_0020;

`ifdef UART_PARITY_EN
    localparam int unsigned UART_FRAME_BITS = 11;
`else
    localparam int unsigned UART_FRAME_BITS = 10;
`endif

    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        UART_PARITY = 3'd3,
`endif
        UART_STOP   = 3'd4
    } uart_state_e;

`ifdef UART_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
        return ^b;
    endfunction
`endif

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Pointers carry one extra wrap
// bit so full and empty are told apart without a separate counter.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Full/empty come straight from the registered pointers, so a push in
    // the same cycle as a pop is still refused when the FIFO was full.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage write.
    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update; wrap is implicit in the AW+1 bit arithmetic.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_INC;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_INC;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte writes are queued in sync_fifo and sent
// LSB first as 8N1, or 8E1 when built with UART_PARITY_EN defined.
// txd and tx_status are registered from next-state values so both are
// glitch-free and change on the same edge as the state they describe.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 5208,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_enable,
    output logic       tx_ready,
    output logic       tx_status,
    output logic       tx_overflow,
    output logic [6:0] tx_level,
    output logic       PC_Uart_txd
);

    localparam int unsigned LW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_state_e state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        status_q, status_d;
    logic        overflow_q;
    logic        baud_last;
    logic        push_ok;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [LW-1:0] fifo_level;
    logic [6:0]  level_d;
`ifdef UART_PARITY_EN
    logic        parity_q, parity_d;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_enable),
        .pop   (fifo_pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign baud_last   = (baud_q == BAUD_LAST);
    assign push_ok     = tx_enable && !fifo_full;
    assign tx_ready    = !fifo_full;
    assign tx_level    = 7'(fifo_level);
    assign tx_status   = status_q;
    assign tx_overflow = overflow_q;
    assign PC_Uart_txd = txd_q;

    // Serialiser next-state: baud timing, bit sequencing and FIFO pop.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
`ifdef UART_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            UART_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_dout;
                    bit_idx_d = '0;
                    baud_d    = '0;
                    state_d   = UART_START;
`ifdef UART_PARITY_EN
                    parity_d  = even_parity(fifo_dout);
`endif
                end
            end
            UART_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = UART_DATA;
                end else begin
                    baud_d  = baud_q + 16'd1;
                end
            end
            UART_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                        state_d = UART_PARITY;
`else
                        state_d = UART_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
`ifdef UART_PARITY_EN
            UART_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = UART_STOP;
                end else begin
                    baud_d  = baud_q + 16'd1;
                end
            end
`endif
            UART_STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = UART_IDLE;
                end else begin
                    baud_d  = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = UART_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Line level and idle status as they will be after this edge.
    always_comb begin
        case (state_d)
            UART_START:  txd_d = 1'b0;
            UART_DATA:   txd_d = shift_d[0];
`ifdef UART_PARITY_EN
            UART_PARITY: txd_d = parity_d;
`endif
            default:     txd_d = UART_STOP_LEVEL;
        endcase
        level_d  = tx_level + 7'(push_ok) - 7'(fifo_pop);
        status_d = (state_d == UART_IDLE) && (level_d == 7'd0);
    end

    // Serialiser state, registered outputs and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= UART_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= UART_STOP_LEVEL;
            status_q   <= 1'b1;
            overflow_q <= 1'b0;
`ifdef UART_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            status_q   <= status_d;
            if (tx_enable && fifo_full) overflow_q <= 1'b1;
`ifdef UART_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. A frame-level model (byte queue plus
// a frame bit vector indexed by elapsed cycles / BAUD) predicts every output
// each cycle; outputs are sampled on the falling edge.
module tb_uart_tx_fifo;

    localparam int BAUD  = 4;
    localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * BAUD + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_enable;
    logic       tx_ready;
    logic       tx_status;
    logic       tx_overflow;
    logic [6:0] tx_level;
    logic       PC_Uart_txd;
    logic [10:0] obs;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [7:0]  m_q[$];
    bit          m_busy = 1'b0;
    int          m_t = 0;
    logic [10:0] m_bits = '1;
    bit          m_ovf = 1'b0;

    uart_tx_fifo #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_enable   (tx_enable),
        .tx_ready    (tx_ready),
        .tx_status   (tx_status),
        .tx_overflow (tx_overflow),
        .tx_level    (tx_level),
        .PC_Uart_txd (PC_Uart_txd)
    );

    always #5 clk = ~clk;

    assign obs = {PC_Uart_txd, tx_status, tx_ready, tx_overflow, tx_level};

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    // Expected {txd, status, ready, overflow, level} after the last edge.
    function automatic logic [10:0] exp_obs();
        logic txd;
        txd = m_busy ? m_bits[m_t / BAUD] : 1'b1;
        return {txd, (!m_busy && m_q.size() == 0), (m_q.size() < DEPTH), m_ovf, 7'(m_q.size())};
    endfunction

    // Advance the model by one rising edge using the inputs seen at that edge.
    task automatic model_step();
        logic       full_b;
        logic       do_pop;
        logic [7:0] head;
        if (!reset) begin
            m_q.delete();
            m_busy = 1'b0;
            m_t    = 0;
            m_ovf  = 1'b0;
            return;
        end
        full_b = (m_q.size() == DEPTH);
        do_pop = !m_busy && (m_q.size() != 0);
        head   = 8'h00;
        if (do_pop) head = m_q.pop_front();
        if (tx_enable) begin
            if (full_b) m_ovf = 1'b1;
            else        m_q.push_back(tx_data);
        end
        if (m_busy) begin
            m_t++;
            if (m_t == NB * BAUD) m_busy = 1'b0;
        end else if (do_pop) begin
            m_bits = frame_of(head);
            m_t    = 0;
            m_busy = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (c == 3) reset = 1'b1;
            tx_enable = (c < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            tx_data   = 8'($urandom);
            @(posedge clk); model_step();
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_obs()) begin
                n_bad++;
                $display("FAIL reset cyc %0d: txd/st/rdy/ovf/lvl got %b want %b", c, obs, exp_obs());
            end
        end
    endtask

    task automatic test_single_byte(input logic [7:0] b, input string name);
        for (int c = 0; c < FRAME + 6; c++) begin
            tx_enable = (c == 0);
            tx_data   = b;
            @(posedge clk); model_step();
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_obs()) begin
                n_bad++;
                $display("FAIL %s cyc %0d: txd/st/rdy/ovf/lvl got %b want %b", name, c, obs, exp_obs());
            end
        end
    endtask

    task automatic test_back_to_back();
        int max_lvl = 0;
        for (int c = 0; c < 2 * FRAME + 6; c++) begin
            tx_enable = (c < 2);
            tx_data   = (c == 0) ? 8'hA5 : 8'h3C;
            @(posedge clk); model_step();
            @(negedge clk);
            if (int'(tx_level) > max_lvl) max_lvl = int'(tx_level);
            n_cmp++;
            if (obs !== exp_obs()) begin
                n_bad++;
                $display("FAIL back_to_back cyc %0d: txd/st/rdy/ovf/lvl got %b want %b", c, obs, exp_obs());
            end
        end
        n_cmp++;
        if (max_lvl != 1) begin
            n_bad++;
            $display("FAIL back_to_back peak level: got %0d want 1", max_lvl);
        end
    endtask

    task automatic test_overflow();
        bit saw_not_ready = 1'b0;
        for (int c = 0; c < 10 + 9 * FRAME + 6; c++) begin
            tx_enable = (c < 10);
            tx_data   = 8'(c);
            @(posedge clk); model_step();
            @(negedge clk);
            if (!tx_ready) saw_not_ready = 1'b1;
            n_cmp++;
            if (obs !== exp_obs()) begin
                n_bad++;
                $display("FAIL overflow cyc %0d: txd/st/rdy/ovf/lvl got %b want %b", c, obs, exp_obs());
            end
        end
        n_cmp++;
        if (saw_not_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow ready_low_seen: got %0b want 1", saw_not_ready);
        end
    endtask

    task automatic test_reset_mid_frame();
        int c = 0;
        // Three writes: one goes straight on the line, two stay queued.
        while (!(m_busy && m_t == 4 * BAUD + 1) && c < 100) begin
            tx_enable = (c < 3);
            tx_data   = 8'($urandom);
            @(posedge clk); model_step();
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_obs()) begin
                n_bad++;
                $display("FAIL mid_reset pre cyc %0d: txd/st/rdy/ovf/lvl got %b want %b", c, obs, exp_obs());
            end
            c++;
        end
        n_cmp++;
        if (c >= 100) begin
            n_bad++;
            $display("FAIL mid_reset reach_bit3: got timeout want frame in data bit 3");
        end
        for (int k = 0; k < 3 * FRAME; k++) begin
            reset     = (k != 0);
            tx_enable = 1'b0;
            @(posedge clk); model_step();
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_obs()) begin
                n_bad++;
                $display("FAIL mid_reset post cyc %0d: txd/st/rdy/ovf/lvl got %b want %b", k, obs, exp_obs());
            end
        end
    endtask

    task automatic test_random();
        int budget;
        for (int c = 0; c < 900; c++) begin
            // Sparse traffic first, then a heavy burst that overruns the FIFO.
            tx_enable = (c < 450) ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 50);
            tx_data   = 8'($urandom);
            @(posedge clk); model_step();
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_obs()) begin
                n_bad++;
                $display("FAIL random cyc %0d: txd/st/rdy/ovf/lvl got %b want %b", c, obs, exp_obs());
            end
        end
        tx_enable = 1'b0;
        budget = 0;
        while ((m_busy || m_q.size() != 0) && budget < 1000) begin
            @(posedge clk); model_step();
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_obs()) begin
                n_bad++;
                $display("FAIL random drain cyc %0d: txd/st/rdy/ovf/lvl got %b want %b", budget, obs, exp_obs());
            end
            budget++;
        end
        n_cmp++;
        if (budget >= 1000 || tx_status !== 1'b1) begin
            n_bad++;
            $display("FAIL random drained_idle: got status %b after %0d cycles want 1", tx_status, budget);
        end
    endtask

    initial begin
        reset     = 1'b0;
        tx_enable = 1'b0;
        tx_data   = 8'h00;
        test_reset();
        test_single_byte(8'h55, "single_55");
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
`ifdef UART_PARITY_EN
        test_single_byte(8'h07, "parity_07");
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter sitting directly downstream of the memory-mapped peripheral block.
- Accepts single-cycle byte-write pulses from the peripheral's UART TX register and queues them in a small FIFO.
- Serialises each byte as 8N1 (optionally 8E1) on the PC UART TX pin.
- Reports idle/ready/overflow status back for the peripheral's status register.

Parameters:
- BAUD_DIV, 5208, clock cycles per UART bit (50 MHz / 9600); legal range 2..65535.
- FIFO_DEPTH, 8, FIFO entries; power of two, 2..64.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- tx_data  input  8  byte to enqueue.
- tx_enable  input  1  one-cycle write strobe; enqueues tx_data.
- tx_ready  output  1  FIFO not full.
- tx_status  output  1  high when FIFO empty and serialiser idle; line is quiescent.
- tx_overflow  output  1  sticky; a write arrived while FIFO full.
- tx_level  output  7  current FIFO occupancy, 0..FIFO_DEPTH, zero-extended.
- PC_Uart_txd  output  1  serial line, idle high.

Behaviour:
- One clock domain. Reset is synchronous and active-low, sampled only on the rising edge of clk.
- Reset values:
  - PC_Uart_txd=1, tx_ready=1, tx_status=1, tx_overflow=0, tx_level=0.
  - FIFO pointers cleared; FSM in IDLE; baud counter 0.
- Reset mid-frame aborts the frame: txd=1 after that edge, and queued bytes are discarded.
- FIFO:
  - Registered read/write pointers, each one bit wider than the address; full/empty derive from the pointers.
  - Push on tx_enable when full is low at that edge.
  - If full is high, the byte is dropped and tx_overflow is set. tx_overflow clears only on reset.
  - Full is evaluated before any same-cycle pop: a push while full is dropped even if a pop occurs in that cycle.
  - A push and a pop in the same cycle while not full: both happen, and tx_level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP.
  - IDLE: if FIFO not empty, pop the head into shift register, load bit index 0, reset baud counter, go to START. txd goes low on the edge that enters START, so latency is 1 cycle from the pop edge. A byte pushed into an empty FIFO at edge N is popped at edge N+1 and txd falls at edge N+1.
  - Each of START, DATA bits, PARITY and STOP holds txd for exactly BAUD_DIV cycles. The baud counter counts 0..BAUD_DIV-1; a state/bit advance occurs when the counter equals BAUD_DIV-1.
  - START: txd=0.
  - DATA: txd = shift register bit 0, LSB first. Shift right after each bit; after bit 7, go to the next state.
  - STOP: txd=1. On expiry go to IDLE. IDLE pops the next byte the following cycle, so back-to-back frames have exactly one extra idle-high cycle between the stop bit and the next start bit.
- A frame is 10 bits without the feature, 11 bits with it. Frame length in cycles = bits × BAUD_DIV, plus 1.
- tx_status = (state==IDLE) && FIFO empty, registered-equivalent (no glitches). It rises one cycle after the last stop bit expires.
- tx_level updates on the edge following the push or pop.

Optional Feature:
- UART_PARITY_EN.
- Defined: after DATA, the PARITY state drives even parity (XOR of the 8 data bits) for BAUD_DIV cycles, then STOP. Frame is 8E1.
- Undefined: PARITY state and parity logic are absent; DATA goes straight to STOP. Frame is 8N1.

Decomposition:
- Shared package (uart_pkg):
  - FSM state enum.
  - Constants UART_DATA_BITS=8 and UART_STOP_LEVEL=1'b1.
  - Peripheral address constant for the TX data register (0x40000018) and the status register (0x40000020), shared with the peripheral block.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/level). The serialiser FSM and baud counter stay in the top module.

Test Plan:
- Reset/idle (BAUD_DIV=4): hold reset low 3 cycles, release -> txd=1, tx_status=1, tx_ready=1, tx_level=0 indefinitely.
- Single byte 0x55, BAUD_DIV=4:
  - txd low for 4 cycles starting 1 cycle after the pop.
  - Then data bits 1,0,1,0,1,0,1,0, each 4 cycles; stop high 4 cycles.
  - tx_status returns 1 at frame end.
- Back-to-back 0xA5 then 0x3C written on consecutive cycles:
  - Two correct frames with exactly one idle-high cycle between them.
  - tx_level peaks at 1.
- Overflow, FIFO_DEPTH=8:
  - Write 10 bytes 0x00..0x09 in consecutive cycles.
  - tx_ready goes low while full; tx_overflow=1.
  - Exactly 9 bytes appear on the line, 0x00..0x08; 0x09 is dropped.
- Reset mid-frame: assert reset during data bit 3 with 2 bytes queued -> txd=1 next edge, tx_level=0, no further frames.
- UART_PARITY_EN defined, byte 0x07 -> parity bit 1 after bit 7, then stop; total 11 bit-times.
